// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way set-associative, write-back, write-allocate L1 cache.
// Drives the datapath array strobes and the pmem handshake, and keeps saturating hit/miss counters.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit_comp_out,
  input  logic                 which_tag,
  input  logic                 dirty_out0,
  input  logic                 dirty_out1,
  input  logic                 LRU_out,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 store,
  output logic                 read_data,
  output logic                 read_tag,
  output logic                 read_valid,
  output logic                 read_dirty,
  output logic                 read_LRU,
  output logic                 read_set,
  output logic                 load_tag0,
  output logic                 load_tag1,
  output logic                 load_valid0,
  output logic                 load_valid1,
  output logic                 load_dirty0,
  output logic                 load_dirty1,
  output logic                 load_set0,
  output logic                 load_set1,
  output logic                 load_LRU,
  output logic                 valid_in,
  output logic                 dirty_in,
  output logic                 LRU_in,
  output logic                 data_in_mux_sel,
  output logic                 data_out_mux_sel,
  output logic                 hold_write_en,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_e;

  state_e               state_q, state_d;
  logic                 victim_q, victim_d;
  logic                 refill_q, refill_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;

  logic is_write;
  logic victim_dirty;

  assign is_write     = mem_write;
  assign victim_dirty = LRU_out ? dirty_out1 : dirty_out0;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  // NOTE: state flops use non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d          = state_q;
    victim_d         = victim_q;
    refill_d         = refill_q;
    hit_d            = hit_q;
    miss_d           = miss_q;
    mem_resp         = 1'b0;
    store            = 1'b0;
    read_data        = 1'b1;
    read_tag         = 1'b1;
    read_valid       = 1'b1;
    read_dirty       = 1'b1;
    read_LRU         = 1'b1;
    read_set         = 1'b1;
    load_tag0        = 1'b0;
    load_tag1        = 1'b0;
    load_valid0      = 1'b0;
    load_valid1      = 1'b0;
    load_dirty0      = 1'b0;
    load_dirty1      = 1'b0;
    load_set0        = 1'b0;
    load_set1        = 1'b0;
    load_LRU         = 1'b0;
    valid_in         = 1'b0;
    dirty_in         = 1'b0;
    LRU_in           = 1'b0;
    data_in_mux_sel  = 1'b0;
    data_out_mux_sel = which_tag;
    hold_write_en    = 1'b1;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          store    = 1'b1;
          refill_d = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (hit_comp_out) begin
          mem_resp = 1'b1;
          load_LRU = 1'b1;
          LRU_in   = ~which_tag;
          if (is_write) begin
            hold_write_en   = 1'b0;
            data_in_mux_sel = 1'b1;
            dirty_in        = 1'b1;
            load_dirty0     = ~which_tag;
            load_dirty1     = which_tag;
          end
          // The re-check after a fill is the tail of a miss, not a new hit.
          if (!refill_q && !(&hit_q)) hit_d = hit_q + 1'b1;
          refill_d = 1'b0;
          state_d  = IDLE;
        end else begin
          if (!(&miss_q)) miss_d = miss_q + 1'b1;
          victim_d = LRU_out;
          state_d  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          load_dirty0 = ~victim_q;
          load_dirty1 = victim_q;
          state_d     = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          valid_in    = 1'b1;
          load_tag0   = ~victim_q;
          load_tag1   = victim_q;
          load_valid0 = ~victim_q;
          load_valid1 = victim_q;
          load_set0   = ~victim_q;
          load_set1   = victim_q;
          load_dirty0 = ~victim_q;
          load_dirty1 = victim_q;
          refill_d    = 1'b1;
          state_d     = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs collapse combinationally while reset is held, so an in-flight pmem request drops at once.
    if (rst) begin
      mem_resp         = 1'b0;
      store            = 1'b0;
      read_data        = 1'b0;
      read_tag         = 1'b0;
      read_valid       = 1'b0;
      read_dirty       = 1'b0;
      read_LRU         = 1'b0;
      read_set         = 1'b0;
      load_tag0        = 1'b0;
      load_tag1        = 1'b0;
      load_valid0      = 1'b0;
      load_valid1      = 1'b0;
      load_dirty0      = 1'b0;
      load_dirty1      = 1'b0;
      load_set0        = 1'b0;
      load_set1        = 1'b0;
      load_LRU         = 1'b0;
      valid_in         = 1'b0;
      dirty_in         = 1'b0;
      LRU_in           = 1'b0;
      data_in_mux_sel  = 1'b0;
      data_out_mux_sel = 1'b0;
      hold_write_en    = 1'b1;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
    end
  end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1 cache datapath (8 sets, 256-bit lines). It sits between the CPU-side request pins, the datapath's status outputs and the physical-memory handshake. It decides hit/miss handling, victim write-back, line fill, LRU/valid/dirty updates and `mem_resp`. Saturating hit and miss counters are included for performance measurement.

## Interface
- `CNT_WIDTH`, 16, width of each performance counter.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read`, `mem_write` in 1: CPU request. Both high is treated as a write.
- `hit_comp_out` in 1: datapath tag match with valid bit set.
- `which_tag` in 1: way that matched.
- `dirty_out0`, `dirty_out1` in 1: dirty bits of the indexed set.
- `LRU_out` in 1: LRU way of the indexed set; this is the victim on a miss.
- `pmem_resp` in 1: physical memory completes the current 256-bit read or write.
- `mem_resp` out 1: one-cycle CPU completion pulse.
- `store` out 1: latches the request into the datapath's capture registers.
- `read_data`, `read_tag`, `read_valid`, `read_dirty`, `read_LRU`, `read_set` out 1: array read enables. Held at 1 outside reset.
- `load_tag0/1`, `load_valid0/1`, `load_dirty0/1`, `load_set0/1`, `load_LRU` out 1: array write strobes.
- `valid_in`, `dirty_in`, `LRU_in` out 1: write data for the valid, dirty and LRU arrays.
- `data_in_mux_sel` out 1: line write source. 0 = `pmem_rdata`, 1 = CPU write data.
- `data_out_mux_sel` out 1: read way select. Equals `which_tag`.
- `hold_write_en` out 1: 1 blocks CPU byte writes into the data array.
- `pmem_read`, `pmem_write` out 1: memory request, held until `pmem_resp`.
- `hit_count`, `miss_count` out `CNT_WIDTH`: saturating performance counters.

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL. All outputs are Moore or Mealy decodes of the current state. Every strobe not listed for a state is 0.
- In every state `hold_write_en` = 1, except CHECK on a write hit.
- IDLE
  - `mem_read|mem_write` = 1: assert `store`, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK with `hit_comp_out` = 1 (hit):
  - `mem_resp` = 1; `load_LRU` = 1 with `LRU_in` = `~which_tag`; `data_out_mux_sel` = `which_tag`.
  - On a write, also `hold_write_en` = 0, `data_in_mux_sel` = 1, `load_dirty[which_tag]` = 1, `dirty_in` = 1.
  - Increment `hit_count`, unless this CHECK is the re-check after a FILL. Go to IDLE.
- CHECK with `hit_comp_out` = 0 (miss):
  - Increment `miss_count`. Victim v = `LRU_out`.
  - `dirty_out[v]` = 1: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK
  - `pmem_write` = 1.
  - On `pmem_resp`: `load_dirty[v]` = 1 with `dirty_in` = 0, then go to FILL.
- FILL
  - `pmem_read` = 1, `data_in_mux_sel` = 0.
  - On `pmem_resp`: `load_tag[v]`, `load_valid[v]`, `load_set[v]` and `load_dirty[v]` = 1, with `valid_in` = 1 and `dirty_in` = 0. Then go to CHECK, which now hits.
- v is registered on the CHECK→miss transition, so LRU updates made by other logic cannot retarget the fill.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, any state, including mid-WRITEBACK or mid-FILL):
  - State → IDLE.
  - All outputs = 0 immediately, including `pmem_read`/`pmem_write`; `hold_write_en` = 1.
  - Counters = 0.
  - A memory transaction in flight is abandoned; a `pmem_resp` arriving after reset is ignored in IDLE.
- Hit latency: request seen in IDLE at cycle 0; `mem_resp` in cycle 1.
- Clean miss: CHECK at cycle 1; FILL from cycle 2 until `pmem_resp` at cycle 2+N; CHECK at 3+N with `mem_resp`.
- Dirty miss: N_wb + N_fill + 3 cycles total.
- The CPU holds address, data and request stable until `mem_resp`. The request may drop in the cycle after `mem_resp`; IDLE resamples it then.
- `pmem_read` and `pmem_write` are never high together. Each stays high until the cycle `pmem_resp` is sampled and is 0 in the next state's first cycle.
- `pmem_resp` outside WRITEBACK/FILL is ignored.

## Test plan
- Read miss, clean victim, `pmem_resp` after 4 cycles:
  - `pmem_read` high for cycles 2–6.
  - `load_tag0` = `load_valid0` = 1 in cycle 6.
  - `mem_resp` in cycle 7.
  - `miss_count` = 1, `hit_count` = 0.
- Repeat the same read:
  - `mem_resp` in cycle 1.
  - `load_LRU` = 1 with `LRU_in` = 1.
  - `hit_count` = 1.
- Write hit to way 1, byte enable 4'b0011:
  - `hold_write_en` = 0, `data_in_mux_sel` = 1, `load_dirty1` = 1 with `dirty_in` = 1, all in the `mem_resp` cycle.
- Miss with `LRU_out` = 1 and `dirty_out1` = 1:
  - WRITEBACK asserts `pmem_write` until `pmem_resp`, then clears dirty1.
  - FILL follows; `pmem_read` and `pmem_write` never overlap.
- Assert `rst` mid-FILL:
  - `pmem_read` drops in the same cycle and state is IDLE.
  - A late `pmem_resp` causes no array load strobes.
- Force `miss_count` to all-ones, then issue a miss: the counter holds at all-ones.
